irq_exc_ctrl: RTL and testbench
===============================

Name: irq_exc_ctrl

Overview:
- Parametrised interrupt/exception controller for the MIPS core; successor to the single-line IRQ/kernel gating in the control decoder.
- Accepts NUM_IRQ external request lines plus the decoder's illegal-opcode flag, tracks kernel mode, latches pending/masked requests, and prioritises them.
- Emits a one-cycle redirect to the handler vector with saved EPC and cause. Sits beside the control decoder and feeds the PC-select mux.

Parameters:
- NUM_IRQ, 4, number of external interrupt lines (1..16).
- EDGE_MASK, 4'b0000, per-line trigger mode: 1 = rising-edge, 0 = level.
- IRQ_VECTOR, 32'h80000004, handler address for interrupts.
- EXC_VECTOR, 32'h80000008, handler address for exceptions.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high.
- irq_in  in  NUM_IRQ  external requests.
- mask_we  in  1  write strobe for the enable-mask register.
- mask_wdata  in  NUM_IRQ  new mask value (1 = enabled).
- pc_in  in  32  PC of the instruction in decode.
- illegal_op  in  1  undefined opcode/funct flagged by the decoder.
- kernel_exit  in  1  jr to a user address (target bit31 = 0) retiring while in kernel.
- stall  in  1  pipeline hold; no take is allowed while high.
- take  out  1  one-cycle redirect pulse.
- redirect_pc  out  32  handler vector, valid when take = 1.
- epc  out  32  saved return address.
- cause  out  5  bit4 = exception; bits3:0 = IRQ index.
- kernel  out  1  kernel-mode flag.
- pending  out  NUM_IRQ  latched, unmasked requests.

Behaviour:
- Reset (async): state=USER, kernel=0, take=0, epc=0, cause=0, mask=all-ones, pending=0, edge history=0.
- Level lines: pending[i] follows irq_in[i] registered, one cycle of latency.
- Edge lines: pending[i] sets on a 0→1 transition and clears only when that line is taken.
- pending is visible as pending & mask; the mask changes the cycle after mask_we.
- FSM USER: when stall=0 and (illegal_op or any enabled pending), go to TAKE.
  - Exception beats interrupts; the lowest IRQ index wins among interrupts.
- TAKE (1 cycle):
  - take=1 and kernel=1.
  - Exception: redirect_pc=EXC_VECTOR, epc=pc_in+4, cause={1,4'h0}.
  - Interrupt: redirect_pc=IRQ_VECTOR, epc=pc_in, so the instruction re-executes; cause={0,idx}.
  - Clear pending[idx] if that line is edge-triggered.
  - Next state: KERNEL.
- KERNEL:
  - Interrupts are not taken. Requests keep latching into pending.
  - illegal_op in kernel is ignored: no take, no epc/cause update.
  - kernel_exit moves to USER and sets kernel=0 the next cycle.
- USER with pc_in[31]=1 (kernel-space PC): treated as kernel for gating; no take.
- Simultaneous kernel_exit and a pending request: return to USER first; the request is taken no earlier than the cycle after.
- mask_we during TAKE is honoured; the take still completes.
- stall high in USER defers the take; pending is held.
- Reset mid-TAKE: the take pulse is squashed and all state returns to reset values.

Optional Feature:
- Macro: IRQ_SYNC_EN.
- Defined: irq_in passes through a 2-flop synchroniser per line before edge/level detection; request-to-pending latency is 3 cycles.
- Undefined: irq_in is assumed synchronous to clk; latency is 1 cycle.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - cause encoding constants: CAUSE_EXC_BIT, CAUSE_IRQ_W.
  - vector addresses: IRQ_VECTOR_DEF, EXC_VECTOR_DEF, RESET_VECTOR.
  - FSM state enum: USER, TAKE, KERNEL.
- One sub-module: irq_prio_enc, a parametrised lowest-index priority encoder returning a valid flag and a 4-bit index.

Test Plan:
- Reset with irq_in=4'b0010 held high → take=0 while reset=1; after release, take pulses 2 cycles later with cause=5'h01, redirect_pc=32'h80000004, kernel=1.
- In USER, illegal_op=1 and irq_in[0]=1 in the same cycle, pc_in=32'h00000040 → cause=5'h10, redirect_pc=32'h80000008, epc=32'h00000044.
- mask_wdata=4'b1110 then irq_in=4'b0001 → no take; pending=0; then mask 4'b1111 → take with cause=5'h00.
- EDGE_MASK=4'b0100: pulse irq_in[2] for one cycle while kernel=1 → pending[2]=1 held; kernel_exit → take on the next cycle with cause=5'h02, then pending[2]=0.
- stall=1 for 3 cycles with irq_in[3]=1 → take only in the cycle after stall falls; epc equals the pc_in presented in that cycle.
- Assert reset during the TAKE cycle → take drops immediately, kernel=0, epc=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
// Shared definitions for the MIPS control path. The interrupt/exception
// controller and the control decoder both use them.
//   CAUSE_EXC_BIT / CAUSE_IRQ_W : layout of the cause word ({exc, irq index})
//   *_VECTOR_DEF / RESET_VECTOR : default handler and reset addresses
//   irq_state_e                 : controller FSM states
//   makeCause()                 : packs an exception flag and an IRQ index
package mips_ctrl_pkg;

  localparam int CAUSE_EXC_BIT = 4;
  localparam int CAUSE_IRQ_W   = 4;

  localparam logic [31:0] IRQ_VECTOR_DEF = 32'h8000_0004;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h8000_0008;
  localparam logic [31:0] RESET_VECTOR   = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    USER   = 2'd0,
    TAKE   = 2'd1,
    KERNEL = 2'd2
  } irq_state_e;

  // An exception always reports index 0, so callers pass 0 when isExc is set.
  function automatic logic [CAUSE_IRQ_W:0] makeCause(
    input logic                   isExc,
    input logic [CAUSE_IRQ_W-1:0] idx
  );
    makeCause = {isExc, idx};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc
// Lowest-index-wins priority encoder for the pending interrupt vector.
//   req_i   [W] : request vector
//   valid_o     : at least one request is set
//   idx_o   [4] : index of the lowest set request (0 when none are set)
module irq_prio_enc #(
  parameter int W = 4
) (
  input  logic [W-1:0] req_i,
  output logic         valid_o,
  output logic [3:0]   idx_o
);

  // Scanning from the top down lets the lowest set index overwrite the others.
  always_comb begin
    valid_o = |req_i;
    idx_o   = 4'd0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = 4'(i);
    end
  end

endmodule

// File: rtl/irq_exc_ctrl.sv
// irq_exc_ctrl
// Interrupt/exception controller for the MIPS core. It latches and masks
// external requests, tracks kernel mode, and issues a one-cycle redirect to the
// handler vector. The redirect carries the saved EPC and the cause.
// Optional build macro: IRQ_SYNC_EN
//   When defined, it adds a 2-flop synchroniser on each irq_in line.
//   Request-to-pending latency is then 3 cycles instead of 1.
// Ports:
//   clk, reset             : core clock, asynchronous active-high reset
//   irq_in      [NUM_IRQ]  : external interrupt requests
//   mask_we, mask_wdata    : enable-mask write (1 = enabled)
//   pc_in       [32]       : PC of the instruction in decode
//   illegal_op             : undefined opcode flagged by the decoder
//   kernel_exit            : return-to-user jump retiring in kernel
//   stall                  : pipeline hold, blocks any take
//   take                   : one-cycle redirect pulse
//   redirect_pc [32]       : handler vector, valid with take
//   epc         [32]       : saved return address
//   cause       [5]        : {exception, irq index}
//   kernel                 : kernel-mode flag
//   pending     [NUM_IRQ]  : latched requests gated by the mask
module irq_exc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int                 NUM_IRQ    = 4,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK  = '0,
  parameter logic [31:0]        IRQ_VECTOR = IRQ_VECTOR_DEF,
  parameter logic [31:0]        EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_IRQ-1:0]     irq_in,
  input  logic                   mask_we,
  input  logic [NUM_IRQ-1:0]     mask_wdata,
  input  logic [31:0]            pc_in,
  input  logic                   illegal_op,
  input  logic                   kernel_exit,
  input  logic                   stall,
  output logic                   take,
  output logic [31:0]            redirect_pc,
  output logic [31:0]            epc,
  output logic [CAUSE_IRQ_W:0]   cause,
  output logic                   kernel,
  output logic [NUM_IRQ-1:0]     pending
);

  irq_state_e               state_q;
  logic                     take_q;
  logic                     kernel_q;
  logic [31:0]              redirect_q;
  logic [31:0]              epc_q;
  logic [CAUSE_IRQ_W:0]     cause_q;
  logic [NUM_IRQ-1:0]       mask_q;
  logic [NUM_IRQ-1:0]       pendRaw_q;
  logic [NUM_IRQ-1:0]       pendRaw_d;
  logic [NUM_IRQ-1:0]       irqPrev_q;
  logic [NUM_IRQ-1:0]       irqSync;
  logic                     prioValid;
  logic [3:0]               prioIdx;
  logic                     canTake;
  logic                     takeExc;
  logic                     takeIrq;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] syncMeta_q;
  logic [NUM_IRQ-1:0] syncOut_q;

  // Two flops per line: irq_in may come from another clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      syncMeta_q <= '0;
      syncOut_q  <= '0;
    end else begin
      syncMeta_q <= irq_in;
      syncOut_q  <= syncMeta_q;
    end
  end

  assign irqSync = syncOut_q;
`else
  assign irqSync = irq_in;
`endif

  assign pending = pendRaw_q & mask_q;

  irq_prio_enc #(
    .W (NUM_IRQ)
  ) u_prio (
    .req_i   (pending),
    .valid_o (prioValid),
    .idx_o   (prioIdx)
  );

  // A kernel-space PC counts as kernel mode even while the FSM is in USER.
  assign canTake = (state_q == USER) && !stall && !pc_in[31];
  assign takeExc = canTake && illegal_op;
  assign takeIrq = canTake && !illegal_op && prioValid;

  // Level lines copy the input. Edge lines set on a rising edge and hold until
  // that line is taken. When a clear and a new edge land together, the clear wins.
  always_comb begin
    pendRaw_d = pendRaw_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (EDGE_MASK[i]) begin
        pendRaw_d[i] = pendRaw_q[i] | (irqSync[i] & ~irqPrev_q[i]);
        if (takeIrq && (prioIdx == 4'(i))) pendRaw_d[i] = 1'b0;
      end else begin
        pendRaw_d[i] = irqSync[i];
      end
    end
  end

  // Request capture and the mask register. The mask is written in any state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q    <= '1;
      pendRaw_q <= '0;
      irqPrev_q <= '0;
    end else begin
      if (mask_we) mask_q <= mask_wdata;
      pendRaw_q <= pendRaw_d;
      irqPrev_q <= irqSync;
    end
  end

  // Controller FSM. All outputs are registered, so take rises with the entry
  // into TAKE and drops when the FSM moves on to KERNEL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= USER;
      take_q     <= 1'b0;
      kernel_q   <= 1'b0;
      redirect_q <= '0;
      epc_q      <= '0;
      cause_q    <= '0;
    end else begin
      take_q <= 1'b0;
      case (state_q)
        USER: begin
          if (takeExc) begin
            state_q    <= TAKE;
            take_q     <= 1'b1;
            kernel_q   <= 1'b1;
            redirect_q <= EXC_VECTOR;
            epc_q      <= pc_in + 32'd4;
            cause_q    <= makeCause(1'b1, '0);
          end else if (takeIrq) begin
            state_q    <= TAKE;
            take_q     <= 1'b1;
            kernel_q   <= 1'b1;
            redirect_q <= IRQ_VECTOR;
            epc_q      <= pc_in;
            cause_q    <= makeCause(1'b0, prioIdx);
          end
        end
        TAKE: begin
          state_q <= KERNEL;
        end
        KERNEL: begin
          if (kernel_exit) begin
            state_q  <= USER;
            kernel_q <= 1'b0;
          end
        end
        default: begin
          state_q <= USER;
        end
      endcase
    end
  end

  assign take        = take_q;
  assign kernel      = kernel_q;
  assign redirect_pc = redirect_q;
  assign epc         = epc_q;
  assign cause       = cause_q;

endmodule

// File: tb/tb_irq_exc_ctrl.sv
// tb_irq_exc_ctrl
// Self-checking bench for irq_exc_ctrl, built with EDGE_MASK = 4'b0100.
// Each scenario pushes the redirect it expects into a scoreboard queue. A
// negedge monitor pops one entry for every take pulse and compares it.
module tb_irq_exc_ctrl;

  localparam logic [31:0] IRQ_VEC = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC = 32'h8000_0008;

  typedef struct {
    logic [31:0] vec;
    logic [31:0] epc;
    logic [4:0]  cause;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [3:0]  irqIn;
  logic        maskWe;
  logic [3:0]  maskWdata;
  logic [31:0] pcIn;
  logic        illegalOp;
  logic        kernelExit;
  logic        stall;
  logic        take;
  logic [31:0] redirectPc;
  logic [31:0] epc;
  logic [4:0]  cause;
  logic        kernel;
  logic [3:0]  pending;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   takeCount;

  irq_exc_ctrl #(
    .NUM_IRQ   (4),
    .EDGE_MASK (4'b0100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .irq_in      (irqIn),
    .mask_we     (maskWe),
    .mask_wdata  (maskWdata),
    .pc_in       (pcIn),
    .illegal_op  (illegalOp),
    .kernel_exit (kernelExit),
    .stall       (stall),
    .take        (take),
    .redirect_pc (redirectPc),
    .epc         (epc),
    .cause       (cause),
    .kernel      (kernel),
    .pending     (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Every take pulse must match the oldest expected redirect.
  always @(negedge clk) begin
    if (reset === 1'b0 && take === 1'b1) begin
      takeCount++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_take: got take=1 cause=%h epc=%h, required no take", cause, epc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (redirectPc !== e.vec || epc !== e.epc || cause !== e.cause) begin
          errors++;
          $display("[TB] FAIL take_fields: got vec=%h epc=%h cause=%h, required vec=%h epc=%h cause=%h",
                   redirectPc, epc, cause, e.vec, e.epc, e.cause);
        end
      end
    end
  end

  task automatic pushExp(input logic [31:0] vec, input logic [31:0] e, input logic [4:0] c);
    exp_t x;
    x.vec = vec;
    x.epc = e;
    x.cause = c;
    sb.push_back(x);
  endtask

  // Waits a bounded number of cycles for the monitor to record another take.
  task automatic waitTake(input int startCount, input string name);
    int n;
    n = 0;
    while (takeCount == startCount && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (takeCount == startCount) begin
      errors++;
      $display("[TB] FAIL %s_timeout: got no take in 8 cycles, required a take", name);
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset = 1'b1;
    irqIn = 4'b0000;
    maskWe = 1'b0;
    maskWdata = 4'b1111;
    pcIn = 32'h0000_0100;
    illegalOp = 1'b0;
    kernelExit = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int sc;
    @(negedge clk);
    reset = 1'b1;
    irqIn = 4'b0010;
    repeat (2) @(negedge clk);
    checks++;
    if (take !== 1'b0 || kernel !== 1'b0 || epc !== 32'h0 || cause !== 5'h0 || pending !== 4'h0) begin
      errors++;
      $display("[TB] FAIL reset_state: got take=%b kernel=%b epc=%h cause=%h pending=%b, required 0 0 0 0 0",
               take, kernel, epc, cause, pending);
    end
    reset = 1'b0;
    sc = takeCount;
    pushExp(IRQ_VEC, 32'h0000_0100, 5'h01);
    @(negedge clk);
    checks++;
    if (take !== 1'b0 || pending !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL reset_latency1: got take=%b pending=%b, required take=0 pending=0010", take, pending);
    end
    @(negedge clk);
    #1;
    checks++;
    if (take !== 1'b1 || kernel !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_latency2: got take=%b kernel=%b, required 1 1", take, kernel);
    end
    waitTake(sc, "reset");
  endtask

  task automatic test_exception_priority();
    int sc;
    resetDut();
    pcIn = 32'h0000_0040;
    illegalOp = 1'b1;
    irqIn = 4'b0001;
    sc = takeCount;
    pushExp(EXC_VEC, 32'h0000_0044, 5'h10);
    waitTake(sc, "exception");
    repeat (3) @(negedge clk);
    checks++;
    if (kernel !== 1'b1 || epc !== 32'h0000_0044 || cause !== 5'h10 || pending !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL kernel_illegal_ignored: got kernel=%b epc=%h cause=%h pending=%b, required 1 00000044 10 0001",
               kernel, epc, cause, pending);
    end
    illegalOp = 1'b0;
    pcIn = 32'h0000_0200;
    kernelExit = 1'b1;
    @(negedge clk);
    kernelExit = 1'b0;
    sc = takeCount;
    checks++;
    if (take !== 1'b0 || kernel !== 1'b0) begin
      errors++;
      $display("[TB] FAIL exit_first: got take=%b kernel=%b, required 0 0", take, kernel);
    end
    pushExp(IRQ_VEC, 32'h0000_0200, 5'h00);
    waitTake(sc, "after_exit");
  endtask

  task automatic test_mask();
    int sc;
    resetDut();
    maskWe = 1'b1;
    maskWdata = 4'b1110;
    @(negedge clk);
    maskWe = 1'b0;
    irqIn = 4'b0001;
    repeat (3) @(negedge clk);
    checks++;
    if (pending !== 4'b0000 || take !== 1'b0 || kernel !== 1'b0) begin
      errors++;
      $display("[TB] FAIL masked_line: got pending=%b take=%b kernel=%b, required 0000 0 0", pending, take, kernel);
    end
    maskWe = 1'b1;
    maskWdata = 4'b1111;
    sc = takeCount;
    pushExp(IRQ_VEC, 32'h0000_0100, 5'h00);
    @(negedge clk);
    maskWe = 1'b0;
    checks++;
    if (take !== 1'b0 || pending !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL mask_update: got take=%b pending=%b, required 0 0001", take, pending);
    end
    waitTake(sc, "unmask");
  endtask

  task automatic test_edge_kernel_exit();
    int sc;
    resetDut();
    pcIn = 32'h0000_0300;
    illegalOp = 1'b1;
    sc = takeCount;
    pushExp(EXC_VEC, 32'h0000_0304, 5'h10);
    waitTake(sc, "edge_enter");
    illegalOp = 1'b0;
    pcIn = 32'h0000_0400;
    irqIn = 4'b0100;
    @(negedge clk);
    irqIn = 4'b0000;
    repeat (3) @(negedge clk);
    checks++;
    if (pending !== 4'b0100 || kernel !== 1'b1) begin
      errors++;
      $display("[TB] FAIL edge_held: got pending=%b kernel=%b, required 0100 1", pending, kernel);
    end
    kernelExit = 1'b1;
    @(negedge clk);
    kernelExit = 1'b0;
    sc = takeCount;
    pushExp(IRQ_VEC, 32'h0000_0400, 5'h02);
    @(negedge clk);
    #1;
    checks++;
    if (take !== 1'b1) begin
      errors++;
      $display("[TB] FAIL edge_take_cycle: got take=%b, required 1", take);
    end
    waitTake(sc, "edge_take");
    checks++;
    if (pending !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL edge_cleared: got pending=%b, required 0000", pending);
    end
  endtask

  task automatic test_stall();
    int sc;
    resetDut();
    stall = 1'b1;
    irqIn = 4'b1000;
    pcIn = 32'h0000_0500;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (take !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d: got take=%b, required 0", i, take);
      end
    end
    checks++;
    if (pending !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL stall_pending: got pending=%b, required 1000", pending);
    end
    stall = 1'b0;
    pcIn = 32'h0000_0504;
    sc = takeCount;
    pushExp(IRQ_VEC, 32'h0000_0504, 5'h03);
    @(negedge clk);
    #1;
    checks++;
    if (take !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_release: got take=%b, required 1", take);
    end
    waitTake(sc, "stall");
  endtask

  task automatic test_kernel_pc();
    int sc;
    resetDut();
    pcIn = 32'h8000_0100;
    irqIn = 4'b0001;
    repeat (3) @(negedge clk);
    checks++;
    if (take !== 1'b0 || kernel !== 1'b0 || pending !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL kernel_pc_gate: got take=%b kernel=%b pending=%b, required 0 0 0001", take, kernel, pending);
    end
    pcIn = 32'h0000_0120;
    sc = takeCount;
    pushExp(IRQ_VEC, 32'h0000_0120, 5'h00);
    waitTake(sc, "user_pc");
  endtask

  task automatic test_reset_mid_take();
    int sc;
    resetDut();
    irqIn = 4'b0010;
    sc = takeCount;
    pushExp(IRQ_VEC, 32'h0000_0100, 5'h01);
    repeat (2) @(negedge clk);
    checks++;
    if (take !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_take_setup: got take=%b, required 1", take);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (take !== 1'b0 || kernel !== 1'b0 || epc !== 32'h0 || cause !== 5'h0 || pending !== 4'h0) begin
      errors++;
      $display("[TB] FAIL mid_take_reset: got take=%b kernel=%b epc=%h cause=%h pending=%b, required 0 0 0 0 0",
               take, kernel, epc, cause, pending);
    end
    @(negedge clk);
    irqIn = 4'b0000;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (takeCount != sc + 1) begin
      errors++;
      $display("[TB] FAIL mid_take_count: got %0d takes, required %0d", takeCount - sc, 1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    takeCount = 0;
    reset = 1'b1;
    irqIn = 4'b0000;
    maskWe = 1'b0;
    maskWdata = 4'b1111;
    pcIn = 32'h0000_0100;
    illegalOp = 1'b0;
    kernelExit = 1'b0;
    stall = 1'b0;

    test_reset();
    test_exception_priority();
    test_mask();
    test_edge_kernel_exit();
    test_stall();
    test_kernel_pc();
    test_reset_mid_take();

    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
